// File: rtl/int_ctrl.sv
// Six-source interrupt controller: per-source level/edge mode, mask, fixed
// priority (source 0 highest) and a single-level request/service handshake
// towards the CP0 HWInt inputs.
module int_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  irq_src,
   input  logic [1:0]  bus_addr,
   input  logic        bus_we,
   input  logic [31:0] bus_wdata,
   output logic [31:0] bus_rdata,
   output logic [5:0]  hwint,
   input  logic        int_taken
);

   typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

   state_e      state_q, state_d;
   logic [5:0]  samp_q, samp_d;
   logic [5:0]  prev_q, prev_d;
   logic [5:0]  mask_q, mask_d;
   logic [5:0]  mode_q, mode_d;
   logic [5:0]  epend_q, epend_d;   // pending state of edge-mode sources only
   logic [2:0]  active_id_q, active_id_d;

   logic [5:0]  edge_ev;
   logic [5:0]  pend;
   logic [5:0]  act;
   logic [2:0]  top;
   logic        wr_mask, wr_mode, wr_pend, wr_eoi;
   logic        take;
   logic [5:0]  clr;

   assign wr_mask = bus_we && (bus_addr == 2'd0);
   assign wr_mode = bus_we && (bus_addr == 2'd1);
   assign wr_pend = bus_we && (bus_addr == 2'd2);
   assign wr_eoi  = bus_we && (bus_addr == 2'd3);

   assign edge_ev = samp_q & ~prev_q;
   // Level sources show the live sample; edge sources show the sticky bit.
   assign pend    = (mode_q & epend_q) | (~mode_q & samp_q);
   assign act     = pend & mask_q;
   assign take    = (state_q == StReq) && int_taken;

   // Lowest-index active source wins; 7 when nothing is active.
   always_comb begin
      top = 3'd7;
      for (int i = 5; i >= 0; i--) begin
         if (act[i]) top = 3'(i);
      end
   end

   // Next-state for input sampling, registers and edge pending bits.
   always_comb begin
      samp_d  = irq_src;
      prev_d  = samp_q;
      mask_d  = wr_mask ? bus_wdata[5:0] : mask_q;
      mode_d  = wr_mode ? bus_wdata[5:0] : mode_q;
      clr     = wr_pend ? bus_wdata[5:0] : 6'b0;
      // Shift by 7 (no source) yields zero, so no extra guard is needed.
      if (take) clr = clr | (6'd1 << top);
      // A new edge always beats a clear; level-mode bits hold no edge state.
      epend_d = mode_q & (edge_ev | (epend_q & ~clr));
   end

   // Request/service FSM and the latched in-service source id.
   always_comb begin
      state_d     = state_q;
      active_id_d = active_id_q;
      hwint       = 6'b0;
      unique case (state_q)
         StIdle: begin
            if (act != 6'b0) state_d = StReq;
         end
         StReq: begin
            hwint = act;
            if (int_taken) begin
               state_d     = StService;
               active_id_d = top;
            end else if (act == 6'b0) begin
               state_d = StIdle;
            end
         end
         StService: begin
            if (wr_eoi) begin
               state_d     = StIdle;
               active_id_d = 3'd7;
            end
         end
         default: begin
            state_d     = StIdle;
            active_id_d = 3'd7;
         end
      endcase
   end

   // Combinational register read; always reflects pre-write values.
   always_comb begin
      bus_rdata = 32'b0;
      unique case (bus_addr)
         2'd0: bus_rdata = {26'b0, mask_q};
         2'd1: bus_rdata = {26'b0, mode_q};
         2'd2: bus_rdata = {26'b0, pend};
         2'd3: bus_rdata = {24'b0, (state_q == StService), active_id_q, 1'b0, top};
         default: bus_rdata = 32'b0;
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         samp_q      <= 6'b0;
         prev_q      <= 6'b0;
         mask_q      <= 6'b0;
         mode_q      <= 6'b0;
         epend_q     <= 6'b0;
         active_id_q <= 3'd7;
      end else begin
         state_q     <= state_d;
         samp_q      <= samp_d;
         prev_q      <= prev_d;
         mask_q      <= mask_d;
         mode_q      <= mode_d;
         epend_q     <= epend_d;
         active_id_q <= active_id_d;
      end
   end

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: the driver pushes expected outputs for each
// cycle, a negedge monitor pops and compares them against the DUT.
module tb_int_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [5:0]  irq_src = 6'b0;
   logic [1:0]  bus_addr = 2'd0;
   logic        bus_we = 1'b0;
   logic [31:0] bus_wdata = 32'b0;
   logic [31:0] bus_rdata;
   logic [5:0]  hwint;
   logic        int_taken = 1'b0;

   int checks = 0;
   int errors = 0;

   int_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .irq_src   (irq_src),
      .bus_addr  (bus_addr),
      .bus_we    (bus_we),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata),
      .hwint     (hwint),
      .int_taken (int_taken)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       nm;
      bit          chk_rd;
      logic [31:0] rd;
      logic [5:0]  hw;
   } item_t;

   item_t sb[$];

   // Reference model: 0 idle, 1 requesting, 2 in service.
   int          m_st = 0;
   logic [5:0]  m_samp = 0, m_prev = 0, m_mask = 0, m_mode = 0, m_ep = 0;
   logic [2:0]  m_active = 3'd7;

   function automatic logic [5:0] m_pend();
      logic [5:0] p;
      for (int i = 0; i < 6; i++) p[i] = m_mode[i] ? m_ep[i] : m_samp[i];
      return p;
   endfunction

   function automatic logic [2:0] m_top();
      logic [5:0] a;
      a = m_pend() & m_mask;
      for (int i = 0; i < 6; i++) if (a[i]) return 3'(i);
      return 3'd7;
   endfunction

   function automatic logic [31:0] m_read(input logic [1:0] a);
      case (a)
         2'd0: return {26'b0, m_mask};
         2'd1: return {26'b0, m_mode};
         2'd2: return {26'b0, m_pend()};
         default: return {24'b0, (m_st == 2), m_active, 1'b0, m_top()};
      endcase
   endfunction

   function automatic logic [5:0] m_hw();
      return (m_st == 1) ? (m_pend() & m_mask) : 6'b0;
   endfunction

   // Advance the model by one clock edge using the inputs driven this cycle.
   function automatic void m_step();
      logic [5:0] edg, act, nep;
      logic [2:0] t;
      logic       keep;
      if (!rst_n) begin
         m_st = 0; m_samp = 0; m_prev = 0; m_mask = 0; m_mode = 0; m_ep = 0;
         m_active = 3'd7;
         return;
      end
      edg = m_samp & ~m_prev;
      act = m_pend() & m_mask;
      t   = m_top();
      for (int i = 0; i < 6; i++) begin
         keep = m_ep[i];
         if (bus_we && bus_addr == 2'd2 && bus_wdata[i]) keep = 1'b0;
         if (m_st == 1 && int_taken && t == 3'(i)) keep = 1'b0;
         nep[i] = m_mode[i] & (keep | edg[i]);
      end
      case (m_st)
         0: if (act != 0) m_st = 1;
         1: if (int_taken) begin m_st = 2; m_active = t; end
            else if (act == 0) m_st = 0;
         default: if (bus_we && bus_addr == 2'd3) begin m_st = 0; m_active = 3'd7; end
      endcase
      if (bus_we && bus_addr == 2'd0) m_mask = bus_wdata[5:0];
      if (bus_we && bus_addr == 2'd1) m_mode = bus_wdata[5:0];
      m_prev = m_samp;
      m_samp = irq_src;
      m_ep   = nep;
   endfunction

   // One cycle: queue model expectations (plus an optional fixed expectation:
   // c=1 hwint only, c=2 hwint and rdata), then clock and clear pulses.
   task automatic cyc(input string nm, input int c, input logic [31:0] erd,
                      input logic [5:0] ehw);
      item_t it;
      it.nm = {nm, "/model"};
      it.chk_rd = 1'b1;
      it.rd = m_read(bus_addr);
      it.hw = m_hw();
      if (rst_n) sb.push_back(it);
      if (c != 0) begin
         it.nm = nm;
         it.chk_rd = (c == 2);
         it.rd = erd;
         it.hw = ehw;
         sb.push_back(it);
      end
      @(posedge clk);
      m_step();
      #1;
      bus_we    = 1'b0;
      int_taken = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc("idle", 0, 0, 0);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus_we = 1'b1; bus_addr = a; bus_wdata = d;
      cyc("wr", 0, 0, 0);
   endtask

   task automatic do_reset();
      irq_src = 0;
      rst_n = 1'b0;
      cyc("rst", 0, 0, 0);
      rst_n = 1'b1;
   endtask

   // Monitor: compare all expectations queued for the current cycle.
   always @(negedge clk) begin
      while (sb.size() > 0) begin
         item_t it;
         it = sb.pop_front();
         if (it.chk_rd) begin
            checks++;
            if (bus_rdata !== it.rd) begin
               errors++;
               $display("FAIL %s rdata addr=%0d got=%h exp=%h", it.nm, bus_addr, bus_rdata,
                        it.rd);
            end
         end
         checks++;
         if (hwint !== it.hw) begin
            errors++;
            $display("FAIL %s hwint got=%h exp=%h", it.nm, hwint, it.hw);
         end
      end
   end

   initial begin
      @(posedge clk);
      m_step();
      #1;
      rst_n = 1'b1;
      bus_addr = 2'd3;
      cyc("reset_stat", 2, 32'h77, 6'h00);

      // Level source.
      wr(2'd0, 32'h3F); wr(2'd1, 32'h0);
      irq_src = 6'h04; bus_addr = 2'd3;
      cyc("lvl_a", 0, 0, 0);
      cyc("lvl_b", 1, 0, 6'h00);
      cyc("lvl_req", 2, 32'h72, 6'h04);
      int_taken = 1'b1;
      cyc("lvl_take", 0, 0, 0);
      cyc("lvl_svc", 2, 32'hA2, 6'h00);
      wr(2'd3, 32'hFFFF_FFFF);
      cyc("lvl_eoi_idle", 1, 0, 6'h00);
      cyc("lvl_rereq", 1, 0, 6'h04);

      // Edge source.
      do_reset();
      wr(2'd0, 32'h01); wr(2'd1, 32'h01);
      irq_src = 6'h01; cyc("edg_pulse", 0, 0, 0);
      irq_src = 6'h00; bus_addr = 2'd2;
      cyc("edg_samp", 0, 0, 0);
      cyc("edg_pend", 2, 32'h01, 6'h00);
      cyc("edg_req", 2, 32'h01, 6'h01);
      int_taken = 1'b1; cyc("edg_take", 0, 0, 0);
      cyc("edg_svc_pend", 2, 32'h00, 6'h00);
      bus_addr = 2'd3;
      cyc("edg_svc_stat", 2, 32'h87, 6'h00);
      wr(2'd3, 32'h0);
      cyc("edg_eoi", 2, 32'h77, 6'h00);

      // Priority between simultaneous edges.
      do_reset();
      wr(2'd0, 32'h3F); wr(2'd1, 32'h3F);
      irq_src = 6'h12; cyc("pri_edge", 0, 0, 0);
      irq_src = 6'h00; bus_addr = 2'd3;
      idle(2);
      cyc("pri_req", 2, 32'h71, 6'h12);
      int_taken = 1'b1; cyc("pri_take", 0, 0, 0);
      cyc("pri_svc_stat", 2, 32'h94, 6'h00);
      bus_addr = 2'd2;
      cyc("pri_svc_pend", 2, 32'h10, 6'h00);
      wr(2'd3, 32'h0);
      cyc("pri_eoi", 1, 0, 6'h00);
      cyc("pri_rereq", 1, 0, 6'h10);

      // Set beats write-1-clear.
      do_reset();
      wr(2'd1, 32'h08);
      irq_src = 6'h08; cyc("col_rise", 0, 0, 0);
      wr(2'd2, 32'h08);
      bus_addr = 2'd2;
      cyc("col_pend", 2, 32'h08, 6'h00);

      // Mask withdraw in REQ.
      do_reset();
      wr(2'd0, 32'h02);
      irq_src = 6'h02; idle(2);
      cyc("mw_req", 1, 0, 6'h02);
      wr(2'd0, 32'h0);
      cyc("mw_drop", 1, 0, 6'h00);
      int_taken = 1'b1; bus_addr = 2'd3;
      cyc("mw_take_ign", 0, 0, 0);
      cyc("mw_stat", 2, 32'h77, 6'h00);

      // Reset during service.
      do_reset();
      wr(2'd0, 32'h3F);
      irq_src = 6'h04; idle(3);
      int_taken = 1'b1; cyc("rs_take", 0, 0, 0);
      do_reset();
      for (int a = 0; a < 4; a++) begin
         bus_addr = 2'(a);
         cyc("rs_regs", 2, (a == 3) ? 32'h77 : 32'h0, 6'h00);
      end

      // Randomized traffic checked against the model every cycle.
      for (int n = 0; n < 600; n++) begin
         rst_n = ($urandom_range(63) != 0);
         if ($urandom_range(3) == 0) irq_src = 6'($urandom);
         bus_addr  = 2'($urandom);
         bus_we    = ($urandom_range(3) == 0);
         bus_wdata = $urandom;
         int_taken = ($urandom_range(4) == 0);
         cyc("rand", 0, 0, 0);
      end

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain pending=%0d exp=0", sb.size());
      end
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
